frame_sync_parse: RTL and testbench

Upstream deframer for the downlink receive path. It hunts a sync word in the raw byte stream, extracts the 16-bit payload length, and buffers each frame body (payload plus 2 CRC bytes) in a ping-pong RAM. It then replays the body as one contiguous valid burst with a length pulse, which is the form the CRC checker stage downstream requires. Malformed headers and stalled frames are discarded before they reach the checker.

---
 rtl/frame_sync_parse_if.sv | 22 ++
 rtl/frame_sync_parse.sv | 244 ++++++++++++++++++++++++
 tb/tb_frame_sync_parse.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_parse_if.sv
// Byte-stream handshake bundle for frame_sync_parse.
// master drives the raw stream in; slave emits the frame bodies.
interface frame_sync_parse_if;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  frame_data_out;
  logic        data_vld_out;
  logic [15:0] frame_len_out;
  logic        len_vld_out;

  modport master (
    output rx_data, rx_vld,
    input  frame_data_out, data_vld_out,
    input  frame_len_out, len_vld_out
  );

  modport slave (
    input  rx_data, rx_vld,
    output frame_data_out, data_vld_out,
    output frame_len_out, len_vld_out
  );
endinterface

// File: rtl/frame_sync_parse.sv
// Sync-hunting deframer: buffers each frame body in a ping-pong RAM
// and replays it as one contiguous burst with a length pulse.
module frame_sync_parse #(
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int          MAX_LEN   = 1024,
  parameter int          TIMEOUT   = 255
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  frame_sync_parse_if.slave bus,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       len_err_cnt,
  output logic [15:0]       timeout_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int BANK  = MAX_LEN + 2;
  localparam int DEPTH = 2 * BANK;
  localparam int AW    = $clog2(DEPTH);
  localparam int GW    = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] BASE1 = AW'(BANK);

  typedef enum logic [2:0] {
    HUNT0, HUNT1, LEN_H, LEN_L, BODY, DROP
  } w_state_t;

  typedef enum logic [1:0] {
    IDLE, LOAD, EMIT, GAP
  } r_state_t;

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;

  logic [7:0]    mem [DEPTH];
  logic [1:0]    full;
  logic [15:0]   bank_len [2];
  logic [7:0]    len_hi;
  logic [15:0]   cur_len;
  logic [15:0]   w_len;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [GW-1:0] gap_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic          wr_last;
  logic          we;
  logic          done;
  logic          tmo;
  logic          len_bad;
  logic          drop_hit;
  logic          re;
  logic          r_last;
  logic          r_gap;
  logic [7:0]    rdata;
  logic          len_vld;
  logic [15:0]   frame_len;
  logic          rx_vld;
  logic [7:0]    rx_data;

  assign rx_vld  = bus.rx_vld;
  assign rx_data = bus.rx_data;
  assign w_len   = {len_hi, rx_data};
  assign wr_addr = (wr_bank ? BASE1 : '0) + wr_idx;
  assign wr_last = 32'(wr_idx) == 32'(cur_len) + 32'd1;

  assign bus.frame_data_out = rdata;
  assign bus.data_vld_out   = (r_state == EMIT);
  assign bus.frame_len_out  = frame_len;
  assign bus.len_vld_out    = len_vld;

  always_comb begin
    w_next   = w_state;
    tmo      = 1'b0;
    len_bad  = 1'b0;
    drop_hit = 1'b0;
    done     = 1'b0;
    we       = 1'b0;
    if (w_state != HUNT0 && !rx_vld &&
        32'(gap_cnt) + 32'd1 == 32'(TIMEOUT)) begin
      tmo    = 1'b1;
      w_next = HUNT0;
    end else if (rx_vld) begin
      unique case (w_state)
        HUNT0:
          if (rx_data == SYNC_WORD[15:8])
            w_next = HUNT1;
        HUNT1:
          if (rx_data == SYNC_WORD[7:0])
            w_next = LEN_H;
          else if (rx_data != SYNC_WORD[15:8])
            w_next = HUNT0;
        LEN_H:
          w_next = LEN_L;
        LEN_L:
          if (w_len == 16'd0 ||
              32'(w_len) > 32'(MAX_LEN)) begin
            len_bad = 1'b1;
            w_next  = HUNT0;
          end else if (full[wr_bank]) begin
            drop_hit = 1'b1;
            w_next   = DROP;
          end else begin
            w_next = BODY;
          end
        BODY: begin
          we = 1'b1;
          if (wr_last) begin
            done   = 1'b1;
            w_next = HUNT0;
          end
        end
        DROP:
          if (wr_last)
            w_next = HUNT0;
        default:
          w_next = HUNT0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= HUNT0;
      gap_cnt     <= '0;
      len_hi      <= '0;
      cur_len     <= '0;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      len_err_cnt <= '0;
      timeout_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == HUNT0 || rx_vld || tmo)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + GW'(1);
      if (rx_vld && w_state == LEN_H)
        len_hi <= rx_data;
      if (rx_vld && w_state == LEN_L) begin
        cur_len <= w_len;
        wr_idx  <= '0;
      end else if (rx_vld &&
                   (w_state == BODY || w_state == DROP)) begin
        wr_idx <= wr_idx + AW'(1);
      end
      if (len_bad)
        len_err_cnt <= len_err_cnt + 16'd1;
      if (drop_hit)
        drop_cnt <= drop_cnt + 16'd1;
      if (tmo)
        timeout_cnt <= timeout_cnt + 16'd1;
      if (done) begin
        bank_len[wr_bank] <= cur_len;
        wr_bank           <= ~wr_bank;
      end
    end
  end

  // Writer only sets an empty bank, reader only clears a full one.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (r_last)
        full[rd_bank] <= 1'b0;
      if (done)
        full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we)
      mem[wr_addr] <= rx_data;
  end

  always_comb begin
    r_next  = r_state;
    re      = 1'b0;
    r_last  = 1'b0;
    rd_addr = (rd_bank ? BASE1 : '0) +
              ((r_state == EMIT) ? rd_idx + AW'(1) : '0);
    unique case (r_state)
      IDLE:
        if (full[rd_bank])
          r_next = LOAD;
      LOAD: begin
        re     = 1'b1;
        r_next = EMIT;
      end
      EMIT:
        if (32'(rd_idx) == 32'(frame_len) + 32'd1) begin
          r_last = 1'b1;
          r_next = GAP;
        end else begin
          re = 1'b1;
        end
      GAP:
        if (r_gap)
          r_next = IDLE;
      default:
        r_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[rd_addr];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      r_gap     <= 1'b0;
      frame_cnt <= '0;
      len_vld   <= 1'b0;
      frame_len <= '0;
    end else begin
      r_state <= r_next;
      len_vld <= (r_state == LOAD);
      r_gap   <= (r_state == GAP) && !r_gap;
      if (r_state == LOAD) begin
        rd_idx    <= '0;
        frame_len <= bank_len[rd_bank];
      end else if (r_state == EMIT) begin
        rd_idx <= rd_idx + AW'(1);
      end
      if (r_last) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_parse.sv
// Bench for frame_sync_parse: directed cases plus random traffic
// checked every cycle against a schedule-based reference model.
module tb_frame_sync_parse;
  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 40;
  localparam logic [7:0] SH = 8'hEB;
  localparam logic [7:0] SL = 8'h90;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  frame_sync_parse_if bus();
  logic [31:0] frame_cnt;
  logic [15:0] len_err_cnt;
  logic [15:0] timeout_cnt;
  logic [15:0] drop_cnt;

  frame_sync_parse #(
    .SYNC_WORD(16'hEB90),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .bus(bus),
    .frame_cnt(frame_cnt),
    .len_err_cnt(len_err_cnt),
    .timeout_cnt(timeout_cnt),
    .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Reference model: parse state, burst schedule, bank release times
  int ph, gap, rem, ml, wbm, last_end;
  logic [7:0] lh;
  int free_at [2];
  byte unsigned body[$];
  byte unsigned exp_bytes[$];
  int b_start[$];
  int b_len[$];
  int m_fcnt, m_lerr, m_tmo, m_drop, m_flen;

  // Observations used by the directed literal checks
  byte unsigned obs[$];
  int lvld_cyc, lvld_len, idle_run, min_gap;
  bit seen;

  task automatic model_reset();
    ph = 0; gap = 0; rem = 0; ml = 0; wbm = 0;
    last_end = -100; lh = '0;
    free_at[0] = 0; free_at[1] = 0;
    body.delete(); exp_bytes.delete();
    b_start.delete(); b_len.delete();
    m_fcnt = 0; m_lerr = 0; m_tmo = 0;
    m_drop = 0; m_flen = 0;
  endtask

  task automatic finish_frame();
    int st;
    st = (cyc + 3 > last_end + 5) ? cyc + 3 : last_end + 5;
    b_start.push_back(st);
    b_len.push_back(ml);
    foreach (body[i]) exp_bytes.push_back(body[i]);
    last_end = st + ml + 1;
    free_at[wbm] = last_end + 1;
    wbm ^= 1;
  endtask

  task automatic model_in(input bit v, input logic [7:0] b);
    int L;
    if (!v) begin
      if (ph != 0) begin
        gap++;
        if (gap == TIMEOUT) begin
          m_tmo++; ph = 0; gap = 0;
        end
      end
      return;
    end
    gap = 0;
    case (ph)
      0: if (b == SH) ph = 1;
      1: ph = (b == SL) ? 2 : ((b == SH) ? 1 : 0);
      2: begin lh = b; ph = 3; end
      3: begin
        L = int'({lh, b});
        if (L == 0 || L > MAX_LEN) begin
          m_lerr++; ph = 0;
        end else begin
          ml = L; rem = L + 2; body.delete();
          if (cyc < free_at[wbm]) begin
            m_drop++; ph = 5;
          end else begin
            ph = 4;
          end
        end
      end
      4: begin
        body.push_back(b); rem--;
        if (rem == 0) begin finish_frame(); ph = 0; end
      end
      default: begin
        rem--;
        if (rem == 0) ph = 0;
      end
    endcase
  endtask

  always @(negedge sys_clk) begin
    bit act, first;
    if (!rst_n) begin
      model_reset();
    end else begin
      act = 0; first = 0;
      if (b_start.size() > 0) begin
        if (cyc >= b_start[0]) begin
          act = 1;
          first = (cyc == b_start[0]);
          if (first) m_flen = b_len[0];
        end
      end
      check("data_vld_out", bus.data_vld_out, act);
      check("len_vld_out", bus.len_vld_out, first);
      check("frame_len_out", bus.frame_len_out, m_flen);
      check("frame_cnt", frame_cnt, m_fcnt);
      check("len_err_cnt", len_err_cnt, m_lerr);
      check("timeout_cnt", timeout_cnt, m_tmo);
      check("drop_cnt", drop_cnt, m_drop);
      if (act) begin
        check("frame_data_out", bus.frame_data_out,
              exp_bytes.pop_front());
        if (cyc == b_start[0] + b_len[0] + 1) begin
          void'(b_start.pop_front());
          void'(b_len.pop_front());
          m_fcnt++;
        end
      end
      if (bus.len_vld_out) begin
        if (seen && idle_run < min_gap) min_gap = idle_run;
        lvld_cyc = cyc;
        lvld_len = int'(bus.frame_len_out);
      end
      if (bus.data_vld_out) begin
        obs.push_back(bus.frame_data_out);
        seen = 1; idle_run = 0;
      end else begin
        idle_run++;
      end
      model_in(bus.rx_vld, bus.rx_data);
    end
  end

  task automatic step(input bit v, input logic [7:0] d);
    @(posedge sys_clk);
    #1;
    bus.rx_vld = v;
    bus.rx_data = d;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_b(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 19) == 0) idle(TIMEOUT - 1);
      else idle($urandom_range(1, 6));
    end
    step(1'b1, b);
  endtask

  task automatic send_frame(input int len, input bit gaps,
                            output int c2);
    logic [15:0] l16;
    l16 = 16'(len);
    send_b(SH, gaps);
    send_b(SL, gaps);
    send_b(l16[15:8], gaps);
    send_b(l16[7:0], gaps);
    for (int i = 0; i < len + 2; i++)
      send_b(8'($urandom), gaps);
    c2 = cyc;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) step(1'b1, q[i]);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00);
    #1 rst_n = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    obs.delete();
    lvld_cyc = -1; lvld_len = -1;
    idle_run = 0; min_gap = 1000; seen = 0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c2, n, r, L;
    logic [47:0] pk;
    logic [7:0] q[$];
    bus.rx_vld = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    do_reset();

    check("rst_data_vld", bus.data_vld_out, 0);
    check("rst_len_vld", bus.len_vld_out, 0);
    check("rst_frame_len", bus.frame_len_out, 0);
    check("rst_frame_data", bus.frame_data_out, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Basic frame
    q = '{8'hEB, 8'h90, 8'h00, 8'h04, 8'h11, 8'h22,
          8'h33, 8'h44, 8'hC1, 8'hC2};
    send_list(q);
    c2 = cyc;
    idle(12);
    check("basic_latency", lvld_cyc, c2 + 3);
    check("basic_len", lvld_len, 4);
    check("basic_nbytes", obs.size(), 6);
    pk = '0;
    foreach (obs[i]) pk = {pk[39:0], obs[i]};
    check("basic_bytes", pk, 48'h11223344C1C2);
    check("basic_frame_cnt", frame_cnt, 1);

    // Back-to-back then gapped
    do_reset();
    send_frame(8, 1'b0, c2);
    send_frame(8, 1'b0, c2);
    send_frame(3, 1'b1, c2);
    idle(60);
    check("b2b_frame_cnt", frame_cnt, 3);
    check("b2b_min_gap_ok", min_gap >= 2, 1);
    check("b2b_nbytes", obs.size(), 10 + 10 + 5);

    // False sync and leading garbage
    do_reset();
    q = '{8'h12, 8'hEB, 8'h34};
    send_list(q);
    idle(10);
    check("garbage_nbytes", obs.size(), 0);
    q = '{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h00,
          8'h01, 8'hAA, 8'hB1, 8'hB2};
    send_list(q);
    idle(10);
    check("fsync_len", lvld_len, 1);
    pk = '0;
    foreach (obs[i]) pk = {pk[39:0], obs[i]};
    check("fsync_bytes", pk, 48'hAAB1B2);
    check("fsync_frame_cnt", frame_cnt, 1);

    // Length errors, then maximum-length frame
    do_reset();
    q = '{8'hEB, 8'h90, 8'h00, 8'h00,
          8'hEB, 8'h90, 8'h00, 8'h41};
    send_list(q);
    idle(6);
    check("lerr_cnt", len_err_cnt, 2);
    check("lerr_nbytes", obs.size(), 0);
    send_frame(MAX_LEN, 1'b0, c2);
    idle(MAX_LEN + 20);
    check("maxlen_len", lvld_len, MAX_LEN);
    check("maxlen_nbytes", obs.size(), MAX_LEN + 2);
    check("maxlen_frame_cnt", frame_cnt, 1);

    // Timeout boundary
    do_reset();
    q = '{8'hEB, 8'h90, 8'h00, 8'h0A,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_list(q);
    idle(TIMEOUT);
    check("tmo_not_yet", timeout_cnt, 0);
    idle(1);
    check("tmo_fired", timeout_cnt, 1);
    idle(5);
    check("tmo_nbytes", obs.size(), 0);
    send_frame(2, 1'b0, c2);
    idle(12);
    check("tmo_next_frame", frame_cnt, 1);
    check("tmo_next_len", lvld_len, 2);

    // Reset while a burst is being emitted
    do_reset();
    send_frame(2, 1'b0, c2);
    idle(10);
    send_frame(30, 1'b0, c2);
    n = 0;
    while (!bus.data_vld_out && n < 60) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("emit_started", n < 60, 1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data_vld", bus.data_vld_out, 0);
    check("mid_rst_len_vld", bus.len_vld_out, 0);
    check("mid_rst_frame_len", bus.frame_len_out, 0);
    check("mid_rst_frame_data", bus.frame_data_out, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    obs.delete();
    send_frame(5, 1'b0, c2);
    idle(14);
    check("post_rst_frame_cnt", frame_cnt, 1);
    check("post_rst_nbytes", obs.size(), 7);

    // Random traffic against the model
    do_reset();
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        for (int k = 0; k < $urandom_range(1, 5); k++)
          step(1'b1, 8'($urandom));
      end else if (r == 1) begin
        L = ($urandom_range(0, 1) == 0) ? 0 :
            $urandom_range(MAX_LEN + 1, 65535);
        send_b(SH, 1'b0);
        send_b(SL, 1'b0);
        send_b(8'(L >> 8), 1'b0);
        send_b(8'(L), 1'b0);
      end else if (r == 2) begin
        send_b(SH, 1'b0);
        send_b(SL, 1'b0);
        send_b(8'h00, 1'b0);
        send_b(8'd20, 1'b0);
        for (int k = 0; k < $urandom_range(0, 10); k++)
          step(1'b1, 8'($urandom));
        idle(TIMEOUT + $urandom_range(0, 3));
      end else begin
        L = ($urandom_range(0, 2) == 0) ?
            $urandom_range(1, MAX_LEN) :
            $urandom_range(1, 6);
        send_frame(L, $urandom_range(0, 1) == 1, c2);
      end
      idle($urandom_range(0, 3));
    end
    idle(3 * MAX_LEN + 20);
    check("rand_drained", b_start.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
